uart_rx: RTL and testbench
==========================

# uart_rx

Asynchronous serial receiver, 8N1 framing, LSB first; the receive-side counterpart of the team's UART transmitter on the same link. It takes the raw line from the pin, synchronises it, centre-samples each bit from a clock-derived baud timer, and presents each received byte with a one-cycle valid strobe. Frame errors are flagged, and the block recovers without help from the consumer. It sits between the pad and the byte-level command/data logic.

## Interface
- CLK_FRQ, 50000000 — system clock frequency in Hz
- BAUD_RATE, 115200 — line bit rate in bits/s
- clk  input  1  system clock, all logic on rising edge
- areset  input  1  asynchronous, active-high reset
- rx_in  input  1  raw serial line, idle high, asynchronous to clk
- data_out  output  8  last correctly framed byte, held until the next good frame
- data_valid  output  1  one-cycle pulse: data_out updated this cycle
- frame_err  output  1  one-cycle pulse: stop bit sampled low
- parity_err  output  1  one-cycle pulse: parity mismatch (see Configuration)
- rx_busy  output  1  high in every state except IDLE

## Operation
- CLKS_PER_BIT = CLK_FRQ/BAUD_RATE, truncated (default 434). HALF = CLKS_PER_BIT/2, truncated (default 217).
- rx_in passes through a 2-flop synchroniser; the output is rx_s. All decisions use rx_s only.
- Bit timer: cleared on every state entry and after every sample; increments by 1 each clk. Size it as ceil(log2(CLKS_PER_BIT)) bits.
- States: IDLE, START, DATA, [PARITY], STOP, RECOVER.
- IDLE: rx_s==0 → START.
- START: a sample is taken when timer==HALF-1. If rx_s==0 → DATA, bit index 0. If rx_s==1 → IDLE (glitch rejected, no flag).
- DATA: a sample is taken when timer==CLKS_PER_BIT-1. Bit i is written to shift_reg[i]. After bit 7 → PARITY if enabled, else STOP.
- PARITY: sampled like DATA, then → STOP.
- STOP: sampled like DATA.
  - rx_s==1, parity good or disabled → data_out<=shift_reg, data_valid pulse, → IDLE.
  - rx_s==1, parity bad → parity_err pulse, data_out unchanged, → IDLE.
  - rx_s==0 → frame_err pulse (takes precedence over parity_err), data_out unchanged, → RECOVER.
- RECOVER: stays until rx_s==1, then → IDLE. A held-low line (break) therefore produces exactly one frame_err.
- No backpressure. A byte not consumed is overwritten by the next good frame.
- Reset values: data_out=8'h00, data_valid=0, frame_err=0, parity_err=0, rx_busy=0. State=IDLE, synchroniser flops=1.
- areset mid-frame: the partial frame is discarded with no strobes. After release, a line already low is treated as a new start edge.

## Timing
- Let t0 be the first clk edge at which rx_in is sampled low.
  - rx_s goes low at t0+2.
  - START is entered at t0+3.
  - The start-bit sample is at t0+3+HALF-1.
  - Each later sample is exactly CLKS_PER_BIT cycles after the previous one.
- data_valid/frame_err/parity_err are registered and high for the single cycle after the stop sample: t0+3+HALF+9·CLKS_PER_BIT. Default: t0+4126; with parity, t0+4560.
- data_out changes in the same cycle data_valid is high.
- Back-to-back frames: a start edge that lands in the cycle after the stop sample is accepted. No idle gap is required beyond the stop bit itself.
- Tolerates ±2% baud mismatch at the defaults.

## Configuration
- UART_RX_PARITY_EN defined: frame is 8E1. The PARITY state is present. The parity bit must equal the XOR of the 8 data bits, otherwise parity_err is pulsed.
- UART_RX_PARITY_EN undefined: frame is 8N1. The PARITY state is absent and parity_err is tied to 0. The port list is identical in both builds.

## Test plan
- Single frame 8'hA5 at the default baud, ideal timing → data_valid exactly once at t0+4126, data_out==8'hA5, no error strobes.
- 2-cycle low glitch on an idle line → returns to IDLE with no strobes; rx_busy high for HALF+2 cycles at most.
- Frame 8'h3C with the stop bit forced low, then the line held low for 20 bit times, then high → exactly one frame_err, data_out keeps its previous value, and the next frame 8'h81 is received correctly.
- Back-to-back 8'h00, 8'hFF, 8'h55 with no gap, at +2% and then −2% baud → three data_valid pulses with the correct bytes.
- areset asserted halfway through the data bits of 8'hC3 → all outputs are at reset values immediately, and no strobe is produced for the aborted frame.
- With UART_RX_PARITY_EN: 8'h07 with parity bit 1 → data_valid; the same byte with parity bit 0 → parity_err, with data_valid low.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 serial receiver: two-flop synchroniser, centre-sampled bits, one-cycle result strobes.
// Define UART_RX_PARITY_EN to receive 8E1 frames with parity checking instead.
module uart_rx #(
  parameter int CLK_FRQ   = 50000000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       areset,
  input  logic       rx_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       rx_busy
);

  localparam int CLKS_PER_BIT = CLK_FRQ / BAUD_RATE;
  localparam int HALF         = CLKS_PER_BIT / 2;
  localparam int TW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] FULL_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(HALF - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_RECOVER
  } state_t;

  state_t          state;
  logic            rx_meta;
  logic            rx_s;
  logic [TW-1:0]   timer;
  logic [2:0]      bit_idx;
  logic [7:0]      shift_reg;
`ifdef UART_RX_PARITY_EN
  logic            parity_bit;
`else
  assign parity_err = 1'b0;
`endif

  // Synchroniser resets to the idle (high) line level so reset release is not seen as a start edge.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state      <= S_IDLE;
      timer      <= '0;
      bit_idx    <= 3'd0;
      shift_reg  <= 8'h00;
      data_out   <= 8'h00;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      rx_busy    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      timer <= timer + 1'b1;
      case (state)
        S_IDLE: begin
          timer <= '0;
          if (!rx_s) begin
            state   <= S_START;
            rx_busy <= 1'b1;
          end
        end
        // A start bit that is high again at its centre was a glitch.
        S_START: begin
          if (timer == HALF_LAST) begin
            timer <= '0;
            if (!rx_s) begin
              state   <= S_DATA;
              bit_idx <= 3'd0;
            end else begin
              state   <= S_IDLE;
              rx_busy <= 1'b0;
            end
          end
        end
        S_DATA: begin
          if (timer == FULL_LAST) begin
            timer              <= '0;
            shift_reg[bit_idx] <= rx_s;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (timer == FULL_LAST) begin
            timer      <= '0;
            parity_bit <= rx_s;
            state      <= S_STOP;
          end
        end
`endif
        // Framing error wins over parity; a low stop bit waits in RECOVER for the line to idle.
        S_STOP: begin
          if (timer == FULL_LAST) begin
            timer <= '0;
            if (!rx_s) begin
              frame_err <= 1'b1;
              state     <= S_RECOVER;
            end else begin
`ifdef UART_RX_PARITY_EN
              if ((^shift_reg) != parity_bit) begin
                parity_err <= 1'b1;
              end else begin
                data_out   <= shift_reg;
                data_valid <= 1'b1;
              end
`else
              data_out   <= shift_reg;
              data_valid <= 1'b1;
`endif
              state   <= S_IDLE;
              rx_busy <= 1'b0;
            end
          end
        end
        S_RECOVER: begin
          timer <= '0;
          if (rx_s) begin
            state   <= S_IDLE;
            rx_busy <= 1'b0;
          end
        end
        default: begin
          timer   <= '0;
          state   <= S_IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frames drive the line, a negedge monitor pops expected bytes
// from a queue on every data_valid and tallies error strobes.
module tb_uart_rx;

  localparam int CPB  = 50000000 / 115200;
  localparam int HALF = CPB / 2;
`ifdef UART_RX_PARITY_EN
  localparam int NPB = 1;
`else
  localparam int NPB = 0;
`endif
  // Edges from the one sampling rx_in low to the one that raises the result strobe.
  localparam int LAT = 2 + HALF + (9 + NPB) * CPB;

  logic       clk = 1'b0;
  logic       areset;
  logic       rx_in;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       parity_err;
  logic       rx_busy;

  uart_rx dut (
    .clk        (clk),
    .areset     (areset),
    .rx_in      (rx_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .rx_busy    (rx_busy)
  );

  // clock / reset
  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  logic [7:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int ferr_cnt = 0;
  int perr_cnt = 0;
  int busy_cnt = 0;
  int last_valid_cyc = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    if (rx_busy === 1'b1) busy_cnt++;
    if (frame_err === 1'b1) ferr_cnt++;
    if (parity_err === 1'b1) perr_cnt++;
    if (data_valid === 1'b1) begin
      valid_cnt++;
      last_valid_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got data_out %0h with empty queue (cycle %0d)", data_out, cyc);
      end else begin
        check("data_out", {24'h0, data_out}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  // driver tasks; called on a negedge
  task automatic drive_bit(input logic v, input int bc);
    rx_in = v;
    repeat (bc) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input int bc, input logic stop_v, input logic par_v);
    if (stop_v && (NPB == 0 || par_v == ^b)) exp_q.push_back(b);
    drive_bit(1'b0, bc);
    for (int i = 0; i < 8; i++) drive_bit(b[i], bc);
`ifdef UART_RX_PARITY_EN
    drive_bit(par_v, bc);
`endif
    drive_bit(stop_v, bc);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_data_out"},   {24'h0, data_out}, 32'h00);
    check({tag, "_data_valid"}, {31'h0, data_valid}, 32'h0);
    check({tag, "_frame_err"},  {31'h0, frame_err}, 32'h0);
    check({tag, "_parity_err"}, {31'h0, parity_err}, 32'h0);
    check({tag, "_rx_busy"},    {31'h0, rx_busy}, 32'h0);
  endtask

  int t_start;
  int v0;
  int f0;
  int rates[2] = '{443, 425};
  logic [7:0] b2b[3] = '{8'h00, 8'hFF, 8'h55};

  initial begin
    areset = 1'b1;
    rx_in  = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    areset = 1'b0;
    repeat (5) @(negedge clk);

    // single ideal frame, exact strobe timing
    t_start = cyc;
    send_frame(8'hA5, CPB, 1'b1, ^8'hA5);
    check("a5_valid_count", valid_cnt, 1);
    check("a5_valid_cycle", last_valid_cyc, t_start + 1 + LAT);
    check("a5_frame_err", ferr_cnt, 0);
    check("a5_parity_err", perr_cnt, 0);

    // 2-cycle glitch on an idle line
    v0 = valid_cnt;
    busy_cnt = 0;
    rx_in = 1'b0;
    repeat (2) @(negedge clk);
    rx_in = 1'b1;
    repeat (HALF + 20) @(negedge clk);
    check("glitch_busy_seen", busy_cnt > 0, 1);
    check("glitch_busy_max", busy_cnt <= HALF + 2, 1);
    check("glitch_no_valid", valid_cnt, v0);
    check("glitch_no_ferr", ferr_cnt, 0);

    // low stop bit followed by a 20-bit break, then a good frame
    send_frame(8'h3C, CPB, 1'b0, ^8'h3C);
    repeat (20 * CPB) @(negedge clk);
    rx_in = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("break_ferr_once", ferr_cnt, 1);
    check("break_data_kept", {24'h0, data_out}, 32'hA5);
    check("break_no_valid", valid_cnt, v0);
    send_frame(8'h81, CPB, 1'b1, ^8'h81);
    repeat (CPB) @(negedge clk);
    check("after_break_valid", valid_cnt, v0 + 1);

    // back-to-back frames at +2% and -2% bit period
    foreach (rates[r]) begin
      v0 = valid_cnt;
      foreach (b2b[k]) send_frame(b2b[k], rates[r], 1'b1, ^b2b[k]);
      rx_in = 1'b1;
      repeat (2 * CPB) @(negedge clk);
      check($sformatf("b2b_count_%0d", rates[r]), valid_cnt, v0 + 3);
    end

    // areset halfway through the data bits of 8'hC3 (start + 4 data bits driven)
    v0 = valid_cnt;
    f0 = ferr_cnt;
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive_bit(logic'((8'hC3 >> i) & 8'h01), CPB);
    areset = 1'b1;
    #1;
    check_reset_values("abort");
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    areset = 1'b0;
    repeat (12 * CPB) @(negedge clk);
    check("abort_no_valid", valid_cnt, v0);
    check("abort_no_ferr", ferr_cnt, f0);
    check("abort_data_out", {24'h0, data_out}, 32'h00);
    send_frame(8'h5A, CPB, 1'b1, ^8'h5A);
    repeat (CPB) @(negedge clk);
    check("after_abort_valid", valid_cnt, v0 + 1);

`ifdef UART_RX_PARITY_EN
    v0 = valid_cnt;
    send_frame(8'h07, CPB, 1'b1, 1'b1);
    repeat (CPB) @(negedge clk);
    check("par_good_valid", valid_cnt, v0 + 1);
    check("par_good_no_perr", perr_cnt, 0);
    send_frame(8'h07, CPB, 1'b1, 1'b0);
    repeat (CPB) @(negedge clk);
    check("par_bad_perr", perr_cnt, 1);
    check("par_bad_no_valid", valid_cnt, v0 + 1);
`endif

    // final report
    check("queue_empty", exp_q.size(), 0);
    check("total_ferr", ferr_cnt, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
